// File: rtl/word_packer.sv
// Reassembles a stream of HALF_W-bit half-words into registered 2*HALF_W-bit words with valid/ready on both sides.
// Optional macro WORD_PACKER_PARITY_EN adds a registered even-parity output parity_o.
module word_packer #(
   parameter int unsigned HALF_W = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  sel_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [HALF_W-1:0]     data_i,
   input  logic                  flush_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [2*HALF_W-1:0]   data_o,
   output logic                  half_pending_o
`ifdef WORD_PACKER_PARITY_EN
   ,
   output logic                  parity_o
`endif
);

   localparam int unsigned WORD_W = 2 * HALF_W;

   typedef enum logic {
      PH_FIRST  = 1'b0,
      PH_SECOND = 1'b1
   } phase_e;

   phase_e              phase_q, phase_d;
   logic [HALF_W-1:0]   held_q, held_d;
   logic                sel_q, sel_d;
   logic [WORD_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic [WORD_W-1:0]   word_c;
   logic                in_acc_c;
   logic                out_acc_c;
`ifdef WORD_PACKER_PARITY_EN
   logic                parity_q, parity_d;
`endif

   // State registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         phase_q  <= PH_FIRST;
         held_q   <= '0;
         sel_q    <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
`ifdef WORD_PACKER_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         phase_q  <= phase_d;
         held_q   <= held_d;
         sel_q    <= sel_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
`ifdef WORD_PACKER_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Handshake, assembly and next-state logic
   always_comb begin
      phase_d    = phase_q;
      held_d     = held_q;
      sel_d      = sel_q;
      data_d     = data_q;
      valid_d    = valid_q;
`ifdef WORD_PACKER_PARITY_EN
      parity_d   = parity_q;
`endif
      in_ready_o = 1'b0;

      word_c    = sel_q ? {data_i, held_q} : {held_q, data_i};
      out_acc_c = valid_q & out_ready_i;

      // The second half may only land when the output slot is free or draining now
      if (!flush_i) begin
         if (phase_q == PH_FIRST) in_ready_o = 1'b1;
         else                     in_ready_o = !valid_q | out_ready_i;
      end
      in_acc_c = in_valid_i & in_ready_o;

      if (out_acc_c) valid_d = 1'b0;

      if (flush_i) begin
         phase_d = PH_FIRST;
      end else if (in_acc_c) begin
         case (phase_q)
            PH_FIRST: begin
               held_d  = data_i;
               sel_d   = sel_i;
               phase_d = PH_SECOND;
            end
            PH_SECOND: begin
               data_d   = word_c;
               valid_d  = 1'b1;
`ifdef WORD_PACKER_PARITY_EN
               parity_d = ^word_c;
`endif
               phase_d  = PH_FIRST;
            end
            default: phase_d = PH_FIRST;
         endcase
      end
   end

   assign out_valid_o    = valid_q;
   assign data_o         = data_q;
   assign half_pending_o = (phase_q == PH_SECOND);
`ifdef WORD_PACKER_PARITY_EN
   assign parity_o       = parity_q;
`endif

endmodule

// File: tb/tb_word_packer.sv
// Scoreboard bench for word_packer: directed half-word beats push expected words; a monitor checks each output accept.
module tb_word_packer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        sel_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [15:0] data_i;
   logic        flush_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] data_o;
   logic        half_pending_o;
`ifdef WORD_PACKER_PARITY_EN
   logic        parity_o;
`endif

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;
   logic [31:0] exp_q[$];

   word_packer #(.HALF_W(16)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .sel_i         (sel_i),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .data_i        (data_i),
      .flush_i       (flush_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .data_o        (data_o),
      .half_pending_o(half_pending_o)
`ifdef WORD_PACKER_PARITY_EN
      ,
      .parity_o      (parity_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: an output accept happens at the next posedge; inputs only change just after posedges
   always @(negedge clk_i) begin
      if (!rst_i && out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", data_o, 32'hxxxxxxxx);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("word", data_o, e);
`ifdef WORD_PACKER_PARITY_EN
            chk("parity", 32'(parity_o), 32'(^e));
`endif
         end
      end
   end

   task automatic beat(input logic [15:0] d, input logic s);
      bit ok;
      in_valid_i = 1'b1;
      data_i     = d;
      sel_i      = s;
      ok         = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         if (in_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      chk("beat_accept", 32'(ok), 32'd1);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic word(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [31:0] exp);
      beat(a, s);
      beat(b, ~s);
      exp_q.push_back(exp);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      sel_i = 1'b0; in_valid_i = 1'b0; data_i = '0; flush_i = 1'b0; out_ready_i = 1'b0;
      do_reset();

      @(negedge clk_i);
      chk("rst_valid",   32'(out_valid_o),    32'd0);
      chk("rst_data",    data_o,              32'h0);
      chk("rst_pending", 32'(half_pending_o), 32'd0);
      chk("rst_ready",   32'(in_ready_o),     32'd1);
      @(posedge clk_i); #1;

      // Basic assembly, both placements, back to back
      out_ready_i = 1'b1;
      word(16'h1234, 16'hABCD, 1'b1, 32'hABCD1234);
      word(16'h1234, 16'hABCD, 1'b0, 32'h1234ABCD);
      word(16'hCAFE, 16'hF00D, 1'b0, 32'hCAFEF00D);
      repeat (2) @(posedge clk_i); #1;

      // Back-pressure
      out_ready_i = 1'b0;
      word(16'h1234, 16'hABCD, 1'b1, 32'hABCD1234);
      beat(16'h5555, 1'b1);
      @(negedge clk_i);
      chk("bp_pending", 32'(half_pending_o), 32'd1);
      chk("bp_valid",   32'(out_valid_o),    32'd1);
      @(posedge clk_i); #1;
      in_valid_i = 1'b1; data_i = 16'h6666; sel_i = 1'b0;
      @(negedge clk_i);
      chk("bp_stall_ready", 32'(in_ready_o), 32'd0);
      chk("bp_hold_data",   data_o,          32'hABCD1234);
      @(posedge clk_i); #1;
      out_ready_i = 1'b1;
      @(negedge clk_i);
      chk("bp_release_ready", 32'(in_ready_o), 32'd1);
      exp_q.push_back(32'h66665555);
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      @(negedge clk_i);
      chk("bp_still_valid", 32'(out_valid_o), 32'd1);
      @(posedge clk_i); #1;

      // Flush discards a held half
      beat(16'h1111, 1'b1);
      flush_i = 1'b1; in_valid_i = 1'b1; data_i = 16'h9999;
      @(negedge clk_i);
      chk("flush_ready", 32'(in_ready_o), 32'd0);
      @(posedge clk_i); #1;
      flush_i = 1'b0; in_valid_i = 1'b0;
      @(negedge clk_i);
      chk("flush_pending", 32'(half_pending_o), 32'd0);
      @(posedge clk_i); #1;
      word(16'h2222, 16'h3333, 1'b1, 32'h33332222);

      // Latched sel wins over a change before the second half
      beat(16'hAAAA, 1'b1);
      beat(16'hBBBB, 1'b0);
      exp_q.push_back(32'hBBBBAAAA);
      repeat (2) @(posedge clk_i); #1;

      // Reset mid-word with a stalled output word
      out_ready_i = 1'b0;
      beat(16'h0102, 1'b1);
      beat(16'h0304, 1'b1);
      beat(16'h0506, 1'b1);
      @(negedge clk_i);
      chk("pre_rst_pending", 32'(half_pending_o), 32'd1);
      chk("pre_rst_valid",   32'(out_valid_o),    32'd1);
      @(posedge clk_i); #1;
      do_reset();
      @(negedge clk_i);
      chk("mid_rst_valid",   32'(out_valid_o),    32'd0);
      chk("mid_rst_data",    data_o,              32'h0);
      chk("mid_rst_pending", 32'(half_pending_o), 32'd0);
      chk("mid_rst_ready",   32'(in_ready_o),     32'd1);
`ifdef WORD_PACKER_PARITY_EN
      chk("mid_rst_parity",  32'(parity_o),       32'd0);
`endif
      @(posedge clk_i); #1;

      // Odd-parity word after reset
      out_ready_i = 1'b1;
      word(16'h0007, 16'h0000, 1'b1, 32'h00000007);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_i);
      @(negedge clk_i);
      chk("drain", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
